// File: rtl/td4_prog_mem.sv
// TD4 program memory: streamed valid/ready loader, registered 1-cycle fetch.
// Define TD4_PROG_MEM_CHECKSUM_EN to add the load_csum output.
module td4_prog_mem #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [OP_W+IMM_W-1:0]  load_data,
  input  logic                   load_last,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_full,
  output logic [ADDR_W:0]        load_count,
`ifdef TD4_PROG_MEM_CHECKSUM_EN
  output logic [OP_W+IMM_W-1:0]  load_csum,
`endif
  input  logic                   fetch_en,
  input  logic [ADDR_W-1:0]      fetch_addr,
  output logic [OP_W-1:0]        opcode_out,
  output logic [IMM_W-1:0]       immediate_out,
  output logic                   fetch_valid
);

  localparam int W     = OP_W + IMM_W;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] WLAST = {ADDR_W{1'b1}};

  logic [W-1:0]      mem_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic [OP_W-1:0]   op_q;
  logic [IMM_W-1:0]  imm_q;
  logic              fvalid_q;
  logic              beat;

  assign load_ready = (state_q == S_LOAD);
  assign load_busy  = (state_q == S_LOAD);
  assign load_done  = (state_q == S_DONE);
  assign load_full  = full_q;
  assign load_count = count_q;

  // A start pulse takes priority and drops any coincident beat.
  assign beat = load_valid & load_ready & ~load_start;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    full_d  = full_q;
    if (load_start) begin
      state_d = S_LOAD;
      wptr_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (beat) begin
      wptr_d  = wptr_q + 1'b1;
      count_d = count_q + 1'b1;
      if (load_last || (wptr_q == WLAST)) begin
        state_d = S_DONE;
      end
      full_d = ~load_last & (wptr_q == WLAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (beat) begin
      mem_q[wptr_q] <= load_data;
    end
  end

  // Reads sample the pre-edge array, giving read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      imm_q    <= '0;
      fvalid_q <= 1'b0;
    end else begin
      fvalid_q <= fetch_en;
      if (fetch_en) begin
        {imm_q, op_q} <= mem_q[fetch_addr];
      end
    end
  end

  assign opcode_out    = op_q;
  assign immediate_out = imm_q;
  assign fetch_valid   = fvalid_q;

`ifdef TD4_PROG_MEM_CHECKSUM_EN
  logic [W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (load_start) begin
      csum_d = '0;
    end else if (beat) begin
      csum_d = csum_q + load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign load_csum = csum_q;
`endif

endmodule
